// File: rtl/minx_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// minx_bus_arbiter_if
//
// Purpose : bundles every bus-side signal of the MINX bus arbiter. This
//           covers the CPU bus and its release handshake, the secondary
//           master request/grant and bus slices, the peripheral read-data
//           window and the muxed external bus. Clock and reset are not part
//           of the bundle.
//
// Modports:
//   slave  - the arbiter's view. It samples the CPU, master, peripheral and
//            memory inputs and drives the request, grant, mux and owner
//            outputs.
//   master - the view of the surrounding system (CPU, masters, memory and
//            peripherals). It is the mirror image of the slave view.
//
// Handshake:
//   cpu_bus_request/cpu_bus_ack behave as a level request/acknowledge pair.
//   The arbiter raises cpu_bus_request and holds it until it gives the bus
//   back. The CPU raises cpu_bus_ack once it has tri-stated its side and
//   keeps it high while cpu_bus_request stays high.
//   m_request/m_grant behave the same way per master. A master holds
//   m_request for as long as it needs the bus. Its m_grant bit stays set
//   until the cycle after the request falls (or until reset).
//
// Signals:
//   cpu_address_in, cpu_data_in, cpu_read, cpu_write, cpu_bus_status, cpu_bus_ack : CPU -> arbiter
//   cpu_bus_request, cpu_data_out                                                  : arbiter -> CPU
//   m_request, m_address_in, m_data_in, m_read, m_write, m_bus_status              : masters -> arbiter (flat, slice i = master i)
//   m_grant, m_data_out                                                            : arbiter -> masters
//   periph_data_in, bus_data_in                                                    : read data sources
//   bus_address_out, bus_data_out, bus_read, bus_write, bus_status                 : muxed external bus
//   owner                                                                          : current owner (0 = CPU, k = master k-1)
//   arb_state                                                                      : debug view of the arbiter FSM state
// ---------------------------------------------------------------------------
interface minx_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 8,
    parameter int NUM_PERIPH  = 4,
    parameter int OWNER_W     = $clog2(NUM_MASTERS + 1)
);
    // CPU side
    logic [ADDR_W-1:0]             cpu_address_in;
    logic [DATA_W-1:0]             cpu_data_in;
    logic                          cpu_read;
    logic                          cpu_write;
    logic [1:0]                    cpu_bus_status;
    logic                          cpu_bus_request;
    logic                          cpu_bus_ack;
    logic [DATA_W-1:0]             cpu_data_out;

    // Secondary masters
    logic [NUM_MASTERS-1:0]        m_request;
    logic [NUM_MASTERS-1:0]        m_grant;
    logic [NUM_MASTERS*ADDR_W-1:0] m_address_in;
    logic [NUM_MASTERS*DATA_W-1:0] m_data_in;
    logic [NUM_MASTERS-1:0]        m_read;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*2-1:0]      m_bus_status;
    logic [DATA_W-1:0]             m_data_out;

    // Read data sources
    logic [NUM_PERIPH*DATA_W-1:0]  periph_data_in;
    logic [DATA_W-1:0]             bus_data_in;

    // Muxed external bus
    logic [ADDR_W-1:0]             bus_address_out;
    logic [DATA_W-1:0]             bus_data_out;
    logic                          bus_read;
    logic                          bus_write;
    logic [1:0]                    bus_status;
    logic [OWNER_W-1:0]            owner;

    // Debug
    logic [1:0]                    arb_state;

    modport slave (
        input  cpu_address_in, cpu_data_in, cpu_read, cpu_write, cpu_bus_status, cpu_bus_ack,
        input  m_request, m_address_in, m_data_in, m_read, m_write, m_bus_status,
        input  periph_data_in, bus_data_in,
        output cpu_bus_request, cpu_data_out, m_grant, m_data_out,
        output bus_address_out, bus_data_out, bus_read, bus_write, bus_status, owner,
        output arb_state
    );

    modport master (
        output cpu_address_in, cpu_data_in, cpu_read, cpu_write, cpu_bus_status, cpu_bus_ack,
        output m_request, m_address_in, m_data_in, m_read, m_write, m_bus_status,
        output periph_data_in, bus_data_in,
        input  cpu_bus_request, cpu_data_out, m_grant, m_data_out,
        input  bus_address_out, bus_data_out, bus_read, bus_write, bus_status, owner,
        input  arb_state
    );
endinterface

// File: rtl/minx_bus_arbiter.sv
// ---------------------------------------------------------------------------
// minx_bus_arbiter
//
// Purpose : MINX bus interconnect for the CPU plus NUM_MASTERS secondary bus
//           masters (PRC, sound DMA, blitter, ...). It arbitrates the
//           secondary requests and holds the CPU off the bus through its
//           bus_request/bus_ack handshake. It muxes address, data, strobes
//           and status from the current owner. It returns CPU read data
//           either from external memory or from the OR-reduced peripheral
//           register window.
//
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - minx_bus_arbiter_if.slave (see the interface file for signals)
//
// Configuration:
//   MINX_ARB_ROUND_ROBIN_EN - when defined, round-robin priority is used.
//                             The search starts at rr_ptr, and rr_ptr moves
//                             to (granted index + 1) mod NUM_MASTERS on each
//                             grant. When undefined, fixed priority is used
//                             (lowest index wins) and rr_ptr does not exist.
//
// FSM: IDLE -> WAIT_ACK -> GRANT <-> HANDOFF -> IDLE. The state is visible
//      on bus.arb_state for debug.
// ---------------------------------------------------------------------------
module minx_bus_arbiter #(
    parameter int               NUM_MASTERS  = 2,
    parameter int               ADDR_W       = 24,
    parameter int               DATA_W       = 8,
    parameter int               NUM_PERIPH   = 4,
    parameter logic [ADDR_W-1:0] REG_BASE    = 24'h2000,
    parameter int               REG_SIZE     = 256,
    parameter logic [1:0]       BUS_MEM_READ = 2'b01
) (
    input  logic                clk,
    input  logic                reset,
    minx_bus_arbiter_if.slave   bus
);
    localparam int OWNER_W = $clog2(NUM_MASTERS + 1);
    localparam int IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // The window bounds are widened by one bit so that REG_BASE+REG_SIZE
    // cannot wrap back into low addresses.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, REG_BASE};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(REG_SIZE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        GRANT    = 2'd2,
        HANDOFF  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   cpu_req_q, cpu_req_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
`ifdef MINX_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
`endif

    logic                   win_valid;
    logic [IDX_W-1:0]       win_idx;
    logic                   any_req;
    logic                   owner_req;

    logic [ADDR_W-1:0]      mux_addr;
    logic [DATA_W-1:0]      mux_data;
    logic                   mux_read;
    logic                   mux_write;
    logic [1:0]             mux_status;
    logic [DATA_W-1:0]      periph_or;
    logic                   in_window;

    assign any_req   = |bus.m_request;
    // The grant is one-hot and matches the owner, so masking the requests
    // with it yields the owner's own request without a variable index.
    assign owner_req = |(bus.m_request & grant_q);

    // ------------------------------------------------------------------
    // Winner selection from the current requests.
    // ------------------------------------------------------------------
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
`ifdef MINX_ARB_ROUND_ROBIN_EN
        // The first pass searches from rr_ptr upwards. The second pass
        // wraps around to index 0.
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!win_valid && bus.m_request[k] && (IDX_W'(k) >= rr_ptr_q)) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!win_valid && bus.m_request[k]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
`else
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!win_valid && bus.m_request[k]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cpu_req_q <= 1'b0;
            grant_q   <= '0;
            owner_q   <= '0;
`ifdef MINX_ARB_ROUND_ROBIN_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cpu_req_q <= cpu_req_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
`ifdef MINX_ARB_ROUND_ROBIN_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The request, grant and owner are computed here
    // and registered, so each changes exactly one cycle after its cause.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cpu_req_d = cpu_req_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
`ifdef MINX_ARB_ROUND_ROBIN_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    cpu_req_d = 1'b1;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // Losing every request takes precedence over an ack that
                // arrives in the same cycle, because there is no one to grant.
                if (!any_req) begin
                    cpu_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (bus.cpu_bus_ack && win_valid) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = OWNER_W'(win_idx) + OWNER_W'(1);
                    state_d          = GRANT;
`ifdef MINX_ARB_ROUND_ROBIN_EN
                    rr_ptr_d = (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
`endif
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    grant_d = '0;
                    owner_d = '0;
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                // The CPU is still parked, so a pending request is served
                // directly without a fresh request/ack round trip.
                if (win_valid && bus.cpu_bus_ack) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = OWNER_W'(win_idx) + OWNER_W'(1);
                    state_d          = GRANT;
`ifdef MINX_ARB_ROUND_ROBIN_EN
                    rr_ptr_d = (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
`endif
                end else begin
                    cpu_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: owner-based bus mux and read-data routing.
    // ------------------------------------------------------------------
    always_comb begin
        mux_addr   = bus.cpu_address_in;
        mux_data   = bus.cpu_data_in;
        mux_read   = bus.cpu_read;
        mux_write  = bus.cpu_write;
        mux_status = bus.cpu_bus_status;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (owner_q == OWNER_W'(k + 1)) begin
                mux_addr   = bus.m_address_in[k*ADDR_W +: ADDR_W];
                mux_data   = bus.m_data_in[k*DATA_W +: DATA_W];
                mux_read   = bus.m_read[k];
                mux_write  = bus.m_write[k];
                mux_status = bus.m_bus_status[k*2 +: 2];
            end
        end
        // While ownership is in transit, nobody may strobe the bus.
        if (state_q == WAIT_ACK || state_q == HANDOFF) begin
            mux_read   = 1'b0;
            mux_write  = 1'b0;
            mux_status = 2'b00;
        end
    end

    // Peripherals drive zero when not addressed, so OR-ing them selects the
    // active one.
    always_comb begin
        periph_or = '0;
        for (int k = 0; k < NUM_PERIPH; k++) begin
            periph_or = periph_or | bus.periph_data_in[k*DATA_W +: DATA_W];
        end
    end

    assign in_window = ({1'b0, mux_addr} >= WIN_LO) && ({1'b0, mux_addr} < WIN_HI);

    assign bus.cpu_data_out    = (in_window && (mux_status == BUS_MEM_READ) && (owner_q == '0))
                                 ? periph_or : bus.bus_data_in;
    assign bus.m_data_out      = bus.bus_data_in;
    assign bus.bus_address_out = mux_addr;
    assign bus.bus_data_out    = mux_data;
    assign bus.bus_read        = mux_read;
    assign bus.bus_write       = mux_write;
    assign bus.bus_status      = mux_status;
    assign bus.cpu_bus_request = cpu_req_q;
    assign bus.m_grant         = grant_q;
    assign bus.owner           = owner_q;
    assign bus.arb_state       = state_q;

endmodule

// File: tb/tb_minx_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_minx_bus_arbiter
//
// Directed bench for minx_bus_arbiter with NUM_MASTERS=2. Inputs change #1
// after a rising edge and outputs are checked at that same point, so every
// registered effect appears exactly one tick() after its cause.
// ---------------------------------------------------------------------------
module tb_minx_bus_arbiter;
    localparam int NUM_MASTERS = 2;
    localparam int ADDR_W      = 24;
    localparam int DATA_W      = 8;
    localparam int NUM_PERIPH  = 4;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_ACK = 2'd1;
    localparam logic [1:0] S_GRANT    = 2'd2;
    localparam logic [1:0] S_HANDOFF  = 2'd3;

    localparam logic [23:0] CPU_ADDR = 24'h000100;
    localparam logic [23:0] M0_ADDR  = 24'h002010;  // inside the register window
    localparam logic [23:0] M1_ADDR  = 24'hABCDEF;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [1:0] first_g;
    logic [1:0] second_g;

    minx_bus_arbiter_if #(
        .NUM_MASTERS(NUM_MASTERS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PERIPH(NUM_PERIPH)
    ) bus ();

    minx_bus_arbiter #(
        .NUM_MASTERS(NUM_MASTERS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PERIPH(NUM_PERIPH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [1:0] st, input logic req,
                              input logic [1:0] gnt, input logic [1:0] own);
        check({tag, "_state"}, 32'(bus.arb_state), 32'(st));
        check({tag, "_cpu_req"}, 32'(bus.cpu_bus_request), 32'(req));
        check({tag, "_grant"}, 32'(bus.m_grant), 32'(gnt));
        check({tag, "_owner"}, 32'(bus.owner), 32'(own));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.cpu_address_in = CPU_ADDR;
        bus.cpu_data_in    = 8'hC0;
        bus.cpu_read       = 1'b1;
        bus.cpu_write      = 1'b0;
        bus.cpu_bus_status = 2'b01;
        bus.cpu_bus_ack    = 1'b0;
        bus.m_request      = 2'b00;
        bus.m_address_in   = {M1_ADDR, M0_ADDR};
        bus.m_data_in      = {8'hB2, 8'hA1};
        bus.m_read         = 2'b01;
        bus.m_write        = 2'b10;
        bus.m_bus_status   = {2'b10, 2'b01};
        bus.periph_data_in = {8'h00, 8'h00, 8'h11, 8'h00};
        bus.bus_data_in    = 8'h77;

        // ---- Reset state ----
        tick();
        tick();
        check_ctrl("reset", S_IDLE, 1'b0, 2'b00, 2'd0);
        reset = 1'b0;
        tick();
        check_ctrl("idle", S_IDLE, 1'b0, 2'b00, 2'd0);
        check("idle_addr", 32'(bus.bus_address_out), 32'(CPU_ADDR));
        check("idle_read", 32'(bus.bus_read), 32'd1);

        // ---- Single master 0 ----
        bus.m_request = 2'b01;
        tick();
        check_ctrl("sm_req", S_WAIT_ACK, 1'b1, 2'b00, 2'd0);
        check("sm_req_read_forced", 32'(bus.bus_read), 32'd0);
        check("sm_req_addr_cpu", 32'(bus.bus_address_out), 32'(CPU_ADDR));
        tick();
        check_ctrl("sm_wait", S_WAIT_ACK, 1'b1, 2'b00, 2'd0);
        bus.cpu_bus_ack = 1'b1;
        tick();
        check_ctrl("sm_grant", S_GRANT, 1'b1, 2'b01, 2'd1);
        check("sm_addr", 32'(bus.bus_address_out), 32'(M0_ADDR));
        check("sm_data", 32'(bus.bus_data_out), 32'h A1);
        check("sm_read", 32'(bus.bus_read), 32'd1);
        check("sm_status", 32'(bus.bus_status), 32'd1);
        // Window hit with a mem read, but the owner is not the CPU.
        check("sm_cpu_rdata", 32'(bus.cpu_data_out), 32'h77);
        check("sm_m_rdata", 32'(bus.m_data_out), 32'h77);
        tick();
        check_ctrl("sm_hold", S_GRANT, 1'b1, 2'b01, 2'd1);
        bus.m_request = 2'b00;
        tick();
        check_ctrl("sm_handoff", S_HANDOFF, 1'b1, 2'b00, 2'd0);
        check("sm_handoff_read", 32'(bus.bus_read), 32'd0);
        check("sm_handoff_status", 32'(bus.bus_status), 32'd0);
        tick();
        check_ctrl("sm_release", S_IDLE, 1'b0, 2'b00, 2'd0);
        bus.cpu_bus_ack = 1'b0;
        tick();
        check("sm_cpu_back_read", 32'(bus.bus_read), 32'd1);

        // ---- Register window (CPU owns the bus) ----
        bus.periph_data_in = {8'h00, 8'h5A, 8'h00, 8'h00};
        bus.bus_data_in    = 8'h33;
        bus.cpu_address_in = 24'h2080;
        #1;
        check("win_hit", 32'(bus.cpu_data_out), 32'h5A);
        bus.cpu_address_in = 24'h2100;
        #1;
        check("win_above", 32'(bus.cpu_data_out), 32'h33);
        bus.cpu_address_in = 24'h20FF;
        #1;
        check("win_last", 32'(bus.cpu_data_out), 32'h5A);
        bus.cpu_address_in = 24'h2000;
        #1;
        check("win_first", 32'(bus.cpu_data_out), 32'h5A);
        bus.cpu_address_in = 24'h1FFF;
        #1;
        check("win_below", 32'(bus.cpu_data_out), 32'h33);
        bus.cpu_address_in = 24'hFFFFFF;
        #1;
        check("win_top", 32'(bus.cpu_data_out), 32'h33);
        bus.periph_data_in = {8'h00, 8'h50, 8'h00, 8'h0A};
        bus.cpu_address_in = 24'h2080;
        #1;
        check("win_or", 32'(bus.cpu_data_out), 32'h5A);
        bus.cpu_read       = 1'b0;
        bus.cpu_write      = 1'b1;
        bus.cpu_bus_status = 2'b10;
        #1;
        check("win_write", 32'(bus.cpu_data_out), 32'h33);
        bus.cpu_read       = 1'b1;
        bus.cpu_write      = 1'b0;
        bus.cpu_bus_status = 2'b01;
        bus.cpu_address_in = CPU_ADDR;

        // ---- Both masters together, ack held ----
`ifdef MINX_ARB_ROUND_ROBIN_EN
        // Master 0 was granted last, so the pointer now sits at master 1.
        first_g  = 2'b10;
        second_g = 2'b01;
`else
        first_g  = 2'b01;
        second_g = 2'b10;
`endif
        bus.m_request = 2'b11;
        tick();
        check_ctrl("dual_req", S_WAIT_ACK, 1'b1, 2'b00, 2'd0);
        bus.cpu_bus_ack = 1'b1;
        tick();
        check_ctrl("dual_first", S_GRANT, 1'b1, first_g, (first_g == 2'b01) ? 2'd1 : 2'd2);
        bus.m_request = second_g;
        tick();
        check_ctrl("dual_handoff", S_HANDOFF, 1'b1, 2'b00, 2'd0);
        tick();
        check_ctrl("dual_second", S_GRANT, 1'b1, second_g, (second_g == 2'b01) ? 2'd1 : 2'd2);
        if (second_g == 2'b10) begin
            check("dual_m1_addr", 32'(bus.bus_address_out), 32'(M1_ADDR));
            check("dual_m1_write", 32'(bus.bus_write), 32'd1);
            check("dual_m1_status", 32'(bus.bus_status), 32'd2);
            check("dual_m1_data", 32'(bus.bus_data_out), 32'hB2);
        end else begin
            check("dual_m0_addr", 32'(bus.bus_address_out), 32'(M0_ADDR));
            check("dual_m0_read", 32'(bus.bus_read), 32'd1);
        end
        bus.m_request = 2'b00;
        tick();
        check_ctrl("dual_handoff2", S_HANDOFF, 1'b1, 2'b00, 2'd0);
        tick();
        check_ctrl("dual_release", S_IDLE, 1'b0, 2'b00, 2'd0);
        bus.cpu_bus_ack = 1'b0;
        tick();

        // ---- Request withdrawn before the ack ----
        bus.m_request = 2'b10;
        tick();
        check_ctrl("wd_req", S_WAIT_ACK, 1'b1, 2'b00, 2'd0);
        bus.m_request = 2'b00;
        tick();
        check_ctrl("wd_idle", S_IDLE, 1'b0, 2'b00, 2'd0);
        bus.cpu_bus_ack = 1'b1;
        tick();
        check_ctrl("wd_late_ack", S_IDLE, 1'b0, 2'b00, 2'd0);
        bus.cpu_bus_ack = 1'b0;
        tick();

        // ---- Reset during GRANT ----
        bus.m_request = 2'b01;
        tick();
        bus.cpu_bus_ack = 1'b1;
        tick();
        check_ctrl("rst_grant", S_GRANT, 1'b1, 2'b01, 2'd1);
        reset = 1'b1;
        tick();
        check_ctrl("rst_mid", S_IDLE, 1'b0, 2'b00, 2'd0);
        check("rst_addr_cpu", 32'(bus.bus_address_out), 32'(CPU_ADDR));
        reset           = 1'b0;
        bus.m_request   = 2'b00;
        bus.cpu_bus_ack = 1'b0;
        tick();
        check_ctrl("rst_after", S_IDLE, 1'b0, 2'b00, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/minx_bus_arbiter.md
Name: minx_bus_arbiter

Overview:
- Parametrised bus interconnect for the MINX top level; generalises the fixed CPU/PRC bus switch to the CPU plus NUM_MASTERS secondary bus masters (PRC, future sound DMA, blitter, ...).
- Arbitrates secondary requests, holds the CPU off the bus via its bus_request/bus_ack handshake, and muxes address/data/strobes/status from the current owner.
- Routes read data back to the CPU from either external memory or the OR-reduced peripheral register window.

Parameters:
- NUM_MASTERS, 2, number of secondary bus masters (1..8).
- ADDR_W, 24, bus address width.
- DATA_W, 8, bus data width.
- NUM_PERIPH, 4, number of peripheral read-data inputs OR-reduced in the register window.
- REG_BASE, 24'h2000, first address of the peripheral register window.
- REG_SIZE, 256, window size in bytes; the window is REG_BASE to REG_BASE+REG_SIZE-1 inclusive.
- BUS_MEM_READ, 2'b01, bus_status encoding for a memory read.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_address_in  in  ADDR_W  CPU address.
- cpu_data_in  in  DATA_W  CPU write data.
- cpu_read  in  1  CPU read strobe.
- cpu_write  in  1  CPU write strobe.
- cpu_bus_status  in  2  CPU bus status.
- cpu_bus_request  out  1  asks the CPU to release the bus.
- cpu_bus_ack  in  1  CPU has released the bus.
- cpu_data_out  out  DATA_W  read data returned to the CPU.
- m_request  in  NUM_MASTERS  per-master bus request.
- m_grant  out  NUM_MASTERS  one-hot grant, registered.
- m_address_in  in  NUM_MASTERS*ADDR_W  flat master addresses; master i occupies slice i.
- m_data_in  in  NUM_MASTERS*DATA_W  flat master write data.
- m_read  in  NUM_MASTERS  master read strobes.
- m_write  in  NUM_MASTERS  master write strobes.
- m_bus_status  in  NUM_MASTERS*2  master bus status.
- m_data_out  out  DATA_W  read data to the masters; equals bus_data_in.
- periph_data_in  in  NUM_PERIPH*DATA_W  peripheral read data; each peripheral drives zero when not addressed.
- bus_data_in  in  DATA_W  external memory read data.
- bus_address_out  out  ADDR_W  muxed bus address.
- bus_data_out  out  DATA_W  muxed write data.
- bus_read  out  1  muxed read strobe.
- bus_write  out  1  muxed write strobe.
- bus_status  out  2  muxed bus status.
- owner  out  $clog2(NUM_MASTERS+1)  current owner: 0 is the CPU, k is master k-1.

Behaviour:
- FSM states: IDLE, WAIT_ACK, GRANT, HANDOFF.
- Reset values: state=IDLE, cpu_bus_request=0, m_grant=0, owner=0, rr_ptr=0.
- IDLE: CPU owns the bus. If any m_request is high, set cpu_bus_request=1 the next cycle and go to WAIT_ACK.
- WAIT_ACK: hold cpu_bus_request. On the first cycle with cpu_bus_ack=1:
  - select the winner from the current m_request (priority rule below);
  - the next cycle, m_grant[winner]=1, owner=winner+1, go to GRANT.
  - If all requests have dropped before the ack arrives, deassert cpu_bus_request and return to IDLE.
- GRANT: the grant is held while m_request[owner-1]=1. When it drops, clear m_grant the next cycle and go to HANDOFF.
- HANDOFF (one turnaround cycle, no grant active, owner=0, bus strobes forced to 0):
  - If other requests are pending and cpu_bus_ack is still 1, go to GRANT with the new winner without releasing the CPU.
  - Otherwise deassert cpu_bus_request and go to IDLE.
- Priority (base): fixed, lowest index wins.
- Latency:
  - m_request rising to cpu_bus_request: 1 cycle.
  - cpu_bus_ack to m_grant: 1 cycle.
  - m_request falling to m_grant falling: 1 cycle.
- A grant never changes while its request is still high. At most one m_grant bit is ever set.
- Bus mux (combinational from owner):
  - owner=0 selects the cpu_* signals;
  - owner=k selects master k-1 slices;
  - in WAIT_ACK and HANDOFF, read, write and status are forced to 0.
- CPU read data: cpu_data_out = OR of all periph_data_in when bus_address_out is inside the window, bus_status==BUS_MEM_READ and owner=0; otherwise bus_data_in.
- Address compare uses the full ADDR_W width. No wrap-around: an address at or above REG_BASE+REG_SIZE is outside the window.
- Simultaneous requests: the winner is resolved in the same cycle the ack is sampled.
- A request asserted during HANDOFF is eligible in that cycle.
- Reset mid-transfer: grants drop and the CPU owns the bus on the next cycle; masters must tolerate losing the grant.

Optional Feature:
MINX_ARB_ROUND_ROBIN_EN
- Defined: round-robin priority. rr_ptr advances to the granted index + 1 (mod NUM_MASTERS) on each grant. The search starts at rr_ptr.
- Undefined: fixed priority, lowest index wins. rr_ptr is absent.

Test Plan:
- Single master: NUM_MASTERS=2; raise m_request[0] at cycle 0, cpu_bus_ack at cycle 3 -> cpu_bus_request=1 at cycle 1, m_grant=2'b01 at cycle 4, bus_address_out follows m_address_in[0]; drop the request -> grant 0 next cycle, HANDOFF, cpu_bus_request=0 the cycle after.
- Register window: owner=0, CPU reads 24'h2080 with BUS_MEM_READ, periph_data_in = {8'h00,8'h5A,8'h00,8'h00} -> cpu_data_out=8'h5A. Read at 24'h2100 -> bus_data_in. Write at 24'h2080 -> bus_data_in.
- Both masters request together, ack held: fixed priority -> master 0 granted first, then master 1 via HANDOFF, cpu_bus_request stays 1 throughout. With MINX_ARB_ROUND_ROBIN_EN and a second identical burst -> master 1 granted first.
- Request withdrawn in WAIT_ACK before the ack -> return to IDLE, no grant issued.
- Reset asserted during GRANT -> m_grant=0, owner=0, cpu_bus_request=0 on the next cycle.
